// File: rtl/shared_mem_read_sequencer.sv
// Round-robin read sequencer for the shared memory: arbitrates requesters, issues reads,
// tags returning words and queues them in an in-order response FIFO. Optional stats: SHMEM_RD_STATS_EN.
module shared_mem_read_sequencer #(
   parameter int N_UNITS    = 32,
   parameter int ID_W       = 5,
   parameter int DATA_W     = 256,
   parameter int MEM_LAT    = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_UNITS-1:0]      req_i,
   input  logic [N_UNITS*ID_W-1:0] req_slot_i,
   output logic [N_UNITS-1:0]      gnt_o,
   output logic [ID_W-1:0]         mem_read_unit_id_o,
   output logic                    mem_rd_en_o,
   input  logic [DATA_W-1:0]       mem_read_data_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [ID_W-1:0]         rsp_unit_id_o,
   output logic [DATA_W-1:0]       rsp_data_o
`ifdef SHMEM_RD_STATS_EN
   ,
   output logic [31:0]             stat_grant_cnt_o,
   output logic [31:0]             stat_stall_cnt_o
`endif
);

   // Handshake: a response transfers on a cycle where rsp_valid_o && rsp_ready_i at the
   // rising edge; rsp_unit_id_o/rsp_data_o hold while valid is high and ready is low.
   localparam int CNT_W = $clog2(2 * FIFO_DEPTH + 1);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

   logic [ID_W-1:0]   ptr;
   logic [ID_W-1:0]   gnt_idx;
   logic              gnt_any;
   logic              grant;
   logic              credit_ok;
   logic [CNT_W-1:0]  occupancy;
   logic [CNT_W-1:0]  inflight;
   logic [CNT_W-1:0]  fifo_count;
   int                idx;

   logic [ID_W-1:0]   iss_tag;
   logic [MEM_LAT:1]  pipe_vld;
   logic [ID_W-1:0]   pipe_tag [1:MEM_LAT];
   logic              push;
   logic              pop;

   logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
   logic [ID_W-1:0]   fifo_tag  [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;

   // Search downward so the lowest offset from ptr is the last (winning) assignment.
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      idx     = 0;
      for (int k = N_UNITS - 1; k >= 0; k--) begin
         idx = (int'(ptr) + k) % N_UNITS;
         if (req_i[idx]) begin
            gnt_idx = ID_W'(idx);
            gnt_any = 1'b1;
         end
      end
   end

   // Credit counts issued-but-unwritten reads; a pop this cycle is not credited until next cycle.
   assign occupancy = fifo_count + inflight;
   assign credit_ok = occupancy < CNT_W'(FIFO_DEPTH);
   assign grant     = gnt_any && credit_ok && !rst;

   always_comb begin
      gnt_o = '0;
      if (grant) gnt_o[gnt_idx] = 1'b1;
   end

   assign push        = pipe_vld[MEM_LAT];
   assign rsp_valid_o = (fifo_count != '0);
   assign pop         = rsp_valid_o && rsp_ready_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr                <= '0;
         mem_rd_en_o        <= 1'b0;
         mem_read_unit_id_o <= '0;
         iss_tag            <= '0;
         pipe_vld           <= '0;
         inflight           <= '0;
      end else begin
         mem_rd_en_o <= grant;
         if (grant) begin
            mem_read_unit_id_o <= req_slot_i[gnt_idx*ID_W +: ID_W];
            iss_tag            <= gnt_idx;
            ptr                <= (gnt_idx == ID_W'(N_UNITS - 1)) ? '0 : gnt_idx + ID_W'(1);
         end
         pipe_vld[1] <= mem_rd_en_o;
         for (int k = 2; k <= MEM_LAT; k++) pipe_vld[k] <= pipe_vld[k-1];
         inflight <= inflight + CNT_W'(grant) - CNT_W'(push);
      end
   end

   // Tags travel alongside the valid bits; only the valid bits need clearing.
   always_ff @(posedge clk) begin
      pipe_tag[1] <= iss_tag;
      for (int k = 2; k <= MEM_LAT; k++) pipe_tag[k] <= pipe_tag[k-1];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) begin
            fifo_data[wr_ptr] <= mem_read_data_i;
            fifo_tag[wr_ptr]  <= pipe_tag[MEM_LAT];
            wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
         end
         fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
      end
   end

   assign rsp_unit_id_o = rsp_valid_o ? fifo_tag[rd_ptr]  : '0;
   assign rsp_data_o    = rsp_valid_o ? fifo_data[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && !pop && fifo_count == CNT_W'(FIFO_DEPTH)));
   end

`ifdef SHMEM_RD_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_grant_cnt_o <= '0;
         stat_stall_cnt_o <= '0;
      end else begin
         if (grant) stat_grant_cnt_o <= stat_grant_cnt_o + 32'd1;
         if ((req_i != '0) && !grant) stat_stall_cnt_o <= stat_stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_shared_mem_read_sequencer.sv
// Bench for shared_mem_read_sequencer: directed phases plus random traffic checked against
// a transaction-level model (outstanding queue, round-robin pointer, fixed response latency).
module tb_shared_mem_read_sequencer;
   localparam int N     = 32;
   localparam int IDW   = 5;
   localparam int DW    = 256;
   localparam int LAT   = 1;
   localparam int DEPTH = 4;
   localparam int QW    = 42;

   // clock / reset block
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [N-1:0]     req_i;
   logic [N*IDW-1:0] req_slot_i;
   logic [N-1:0]     gnt_o;
   logic [IDW-1:0]   mem_read_unit_id_o;
   logic             mem_rd_en_o;
   logic [DW-1:0]    mem_read_data_i;
   logic             rsp_valid_o;
   logic             rsp_ready_i;
   logic [IDW-1:0]   rsp_unit_id_o;
   logic [DW-1:0]    rsp_data_o;
`ifdef SHMEM_RD_STATS_EN
   logic [31:0]      stat_grant_cnt_o;
   logic [31:0]      stat_stall_cnt_o;
`endif

   shared_mem_read_sequencer dut (
      .clk                (clk),
      .rst                (rst),
      .req_i              (req_i),
      .req_slot_i         (req_slot_i),
      .gnt_o              (gnt_o),
      .mem_read_unit_id_o (mem_read_unit_id_o),
      .mem_rd_en_o        (mem_rd_en_o),
      .mem_read_data_i    (mem_read_data_i),
      .rsp_valid_o        (rsp_valid_o),
      .rsp_ready_i        (rsp_ready_i),
      .rsp_unit_id_o      (rsp_unit_id_o),
      .rsp_data_o         (rsp_data_o)
`ifdef SHMEM_RD_STATS_EN
      ,
      .stat_grant_cnt_o   (stat_grant_cnt_o),
      .stat_stall_cnt_o   (stat_stall_cnt_o)
`endif
   );

   // shared memory: one-cycle read, garbage when no read was issued
   logic [DW-1:0] mem [N];
   always @(posedge clk)
      mem_read_data_i <= mem_rd_en_o ? mem[mem_read_unit_id_o] : {8{32'($urandom)}};

   // scoreboard: entry = {grant cycle, requester id, slot}
   logic [QW-1:0]  exp_q[$];
   int             ptr_m;
   int             cyc;
   logic           last_en;
   logic [IDW-1:0] last_slot;
   int             n_grant_m;
   int             n_stall_m;
   int             n_pass;
   int             n_total;

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic chk_stats();
`ifdef SHMEM_RD_STATS_EN
      chk("stat_grant", stat_grant_cnt_o, DW'(n_grant_m));
      chk("stat_stall", stat_stall_cnt_o, DW'(n_stall_m));
`endif
   endtask

   // driver: one cycle of stimulus; slot < 0 means random slots per requester
   task automatic step(input logic [N-1:0] req, input logic ready, input int slot);
      int             g;
      logic [N-1:0]   exp_gnt;
      logic           exp_v;
      logic [IDW-1:0] g_slot;
      @(negedge clk);
      req_i       = req;
      rsp_ready_i = ready;
      for (int i = 0; i < N; i++)
         req_slot_i[i*IDW +: IDW] = (slot < 0) ? IDW'($urandom_range(0, N-1)) : IDW'(slot);
      #1;
      g = -1;
      if (exp_q.size() < DEPTH)
         for (int k = 0; k < N; k++)
            if (g < 0 && req[(ptr_m + k) % N]) g = (ptr_m + k) % N;
      exp_gnt = '0;
      if (g >= 0) exp_gnt[g] = 1'b1;
      chk("gnt", gnt_o, exp_gnt);
      chk("rd_en", mem_rd_en_o, last_en);
      chk("rd_addr", mem_read_unit_id_o, last_slot);
      exp_v = (exp_q.size() > 0) && (cyc >= int'(exp_q[0][41:10]) + 2 + LAT);
      chk("rsp_valid", rsp_valid_o, exp_v);
      if (exp_v) begin
         chk("rsp_id", rsp_unit_id_o, exp_q[0][9:5]);
         chk("rsp_data", rsp_data_o, mem[exp_q[0][4:0]]);
      end
      g_slot = (g >= 0) ? req_slot_i[g*IDW +: IDW] : '0;
      @(posedge clk);
      if (exp_v && ready) void'(exp_q.pop_front());
      last_en = (g >= 0);
      if (g >= 0) begin
         last_slot = g_slot;
         exp_q.push_back({32'(cyc), IDW'(g), g_slot});
         ptr_m = (g + 1) % N;
         n_grant_m++;
      end else if (req != '0) begin
         n_stall_m++;
      end
      cyc++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst         = 1'b1;
      req_i       = '0;
      rsp_ready_i = 1'b0;
      @(negedge clk);
      chk("rst_gnt", gnt_o, '0);
      chk("rst_rd_en", mem_rd_en_o, '0);
      chk("rst_rd_addr", mem_read_unit_id_o, '0);
      chk("rst_rsp_valid", rsp_valid_o, '0);
      chk("rst_rsp_id", rsp_unit_id_o, '0);
      chk("rst_rsp_data", rsp_data_o, '0);
      rst = 1'b0;
      exp_q.delete();
      ptr_m     = 0;
      last_en   = 1'b0;
      last_slot = '0;
      n_grant_m = 0;
      n_stall_m = 0;
      cyc       = cyc + 2;
      chk_stats();
   endtask

   initial begin
      logic [N-1:0] r;
      rst = 1'b1; req_i = '0; req_slot_i = '0; rsp_ready_i = 1'b0;
      n_pass = 0; n_total = 0; cyc = 0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < DW / 32; j++) mem[i][j*32 +: 32] = $urandom;
      repeat (2) @(posedge clk);
      do_reset();

      // single read: requester 3, slot 7
      step(32'h0000_0008, 1'b1, 7);
      repeat (5) step('0, 1'b1, -1);

      // all requesters held high with free-running consumer
      repeat (34) step('1, 1'b1, -1);
      repeat (4) step('0, 1'b1, -1);

      // backpressure, then release
      repeat (8) step('1, 1'b0, -1);
      repeat (3) step('1, 1'b1, -1);
      repeat (8) step('0, 1'b1, -1);
      chk_stats();

      // pointer wrap: move ptr to 30, then bits 31 and 1
      step(32'h2000_0000, 1'b1, -1);
      step(32'h8000_0002, 1'b1, -1);
      step(32'h8000_0002, 1'b1, -1);
      repeat (5) step('0, 1'b1, -1);

      // reset with two reads in flight and two entries queued
      repeat (4) step('1, 1'b0, -1);
      do_reset();
      repeat (6) step('0, 1'b1, -1);

      // random traffic
      repeat (400) begin
         case ($urandom_range(0, 3))
            0: r = '0;
            1: r = N'(1) << $urandom_range(0, N-1);
            2: r = $urandom & $urandom;
            default: r = $urandom;
         endcase
         step(r, 1'($urandom_range(0, 3) != 0), -1);
      end
      repeat (8) step('0, 1'b1, -1);
      chk_stats();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
